// File: rtl/uart_pkg.sv
// Shared UART parameters used by the receiver, transmitter and both FIFOs.
package uart_pkg;
    localparam int UART_DBITS     = 8;
    localparam int UART_ADDR_BITS = 4;
endpackage

// File: rtl/uart_fifo_mem.sv
// Register-array storage for the UART FIFOs: synchronous write, asynchronous read.
module uart_fifo_mem
    import uart_pkg::*;
#(
    parameter int DBITS     = UART_DBITS,
    parameter int ADDR_BITS = UART_ADDR_BITS
) (
    input  logic                 clk_100MHz,
    input  logic                 wr_en,
    input  logic [ADDR_BITS-1:0] wr_addr,
    input  logic [DBITS-1:0]     wr_data,
    input  logic [ADDR_BITS-1:0] rd_addr,
    output logic [DBITS-1:0]     rd_data
);

    // Contents are deliberately not reset; the pointers define validity.
    logic [DBITS-1:0] mem [2**ADDR_BITS];

    always_ff @(posedge clk_100MHz) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive-side first-word-fall-through FIFO with occupancy, full/empty and sticky overflow.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DBITS     = UART_DBITS,
    parameter int ADDR_BITS = UART_ADDR_BITS
) (
    input  logic                 clk_100MHz,
    input  logic                 reset,
    input  logic                 wr_en,
    input  logic [DBITS-1:0]     wr_data,
    input  logic                 rd_en,
    input  logic                 clr_overflow,
    output logic [DBITS-1:0]     rd_data,
    output logic                 empty,
    output logic                 full,
    output logic [ADDR_BITS:0]   count,
    output logic                 overflow
);

    logic [ADDR_BITS:0] wr_ptr;
    logic [ADDR_BITS:0] rd_ptr;
    logic               push;
    logic               pop;
    logic               drop;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[ADDR_BITS] != rd_ptr[ADDR_BITS]) &&
                   (wr_ptr[ADDR_BITS-1:0] == rd_ptr[ADDR_BITS-1:0]);
    assign count = wr_ptr - rd_ptr;

    // A push while full is still legal if the same cycle frees a slot.
    assign push = wr_en && (!full || rd_en);
    assign pop  = rd_en && !empty;
    assign drop = wr_en && full && !rd_en;

    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + (ADDR_BITS+1)'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + (ADDR_BITS+1)'(1);
            end
            if (drop) begin
                overflow <= 1'b1;
            end else if (clr_overflow) begin
                overflow <= 1'b0;
            end
        end
    end

    uart_fifo_mem #(
        .DBITS     (DBITS),
        .ADDR_BITS (ADDR_BITS)
    ) u_mem (
        .clk_100MHz (clk_100MHz),
        .wr_en      (push),
        .wr_addr    (wr_ptr[ADDR_BITS-1:0]),
        .wr_data    (wr_data),
        .rd_addr    (rd_ptr[ADDR_BITS-1:0]),
        .rd_data    (rd_data)
    );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: ordering, full/overflow, simultaneous push/pop, wrap and reset.
module tb_uart_rx_fifo;

    logic       clk_100MHz = 1'b0;
    logic       reset;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       rd_en;
    logic       clr_overflow;
    logic [7:0] rd_data;
    logic       empty;
    logic       full;
    logic [4:0] count;
    logic       overflow;

    int n_checks = 0;
    int n_pass   = 0;

    uart_rx_fifo dut (
        .clk_100MHz   (clk_100MHz),
        .reset        (reset),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .rd_en        (rd_en),
        .clr_overflow (clr_overflow),
        .rd_data      (rd_data),
        .empty        (empty),
        .full         (full),
        .count        (count),
        .overflow     (overflow)
    );

    always #5 clk_100MHz = ~clk_100MHz;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one edge; outputs are sampled 1ns after it.
    task automatic tick();
        @(posedge clk_100MHz);
        #1;
    endtask

    task automatic push(input logic [7:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic pop();
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
    endtask

    initial begin
        reset        = 1'b1;
        wr_en        = 1'b0;
        wr_data      = 8'h00;
        rd_en        = 1'b0;
        clr_overflow = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        tick();

        // Reset and idle
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        pop();
        pop();
        check("idle_pop_count", 32'(count), 32'd0);
        check("idle_pop_empty", 32'(empty), 32'd1);
        check("idle_pop_ovf", 32'(overflow), 32'd0);

        // Three bytes in order
        push(8'h11);
        check("first_fwft_data", 32'(rd_data), 32'h11);
        check("first_fwft_empty", 32'(empty), 32'd0);
        push(8'h22);
        push(8'h33);
        check("three_count", 32'(count), 32'd3);
        check("three_rd0", 32'(rd_data), 32'h11);
        pop();
        check("three_rd1", 32'(rd_data), 32'h22);
        check("three_count2", 32'(count), 32'd2);
        pop();
        check("three_rd2", 32'(rd_data), 32'h33);
        pop();
        check("three_count0", 32'(count), 32'd0);
        check("three_empty", 32'(empty), 32'd1);

        // Fill, overflow, drain
        for (int i = 0; i < 16; i++) begin
            push(8'(i));
        end
        check("fill_full", 32'(full), 32'd1);
        check("fill_count", 32'(count), 32'd16);
        check("fill_ovf0", 32'(overflow), 32'd0);
        push(8'hAA);
        check("drop_ovf", 32'(overflow), 32'd1);
        check("drop_count", 32'(count), 32'd16);
        // Drop and clear in the same cycle: set wins
        clr_overflow = 1'b1;
        push(8'hBB);
        clr_overflow = 1'b0;
        check("set_beats_clr", 32'(overflow), 32'd1);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("drain1_%0d", i), 32'(rd_data), 32'(i));
            pop();
        end
        check("drain1_empty", 32'(empty), 32'd1);
        check("drain1_ovf_sticky", 32'(overflow), 32'd1);
        clr_overflow = 1'b1;
        tick();
        clr_overflow = 1'b0;
        check("clr_ovf", 32'(overflow), 32'd0);

        // Push + pop while full
        for (int i = 0; i < 16; i++) begin
            push(8'(i));
        end
        wr_en   = 1'b1;
        wr_data = 8'h55;
        rd_en   = 1'b1;
        tick();
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        check("fullrw_count", 32'(count), 32'd16);
        check("fullrw_full", 32'(full), 32'd1);
        check("fullrw_ovf", 32'(overflow), 32'd0);
        for (int i = 1; i < 16; i++) begin
            check($sformatf("drain2_%0d", i), 32'(rd_data), 32'(i));
            pop();
        end
        check("drain2_last", 32'(rd_data), 32'h55);
        pop();
        check("drain2_empty", 32'(empty), 32'd1);

        // Push + pop while empty: pop ignored
        wr_en   = 1'b1;
        wr_data = 8'h77;
        rd_en   = 1'b1;
        tick();
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        check("emptyrw_count", 32'(count), 32'd1);
        check("emptyrw_data", 32'(rd_data), 32'h77);
        pop();
        check("emptyrw_drained", 32'(count), 32'd0);

        // Alternating push/pop across pointer wrap
        for (int i = 0; i < 20; i++) begin
            push(8'(8'h80 + i));
            check($sformatf("alt_cnt1_%0d", i), 32'(count), 32'd1);
            check($sformatf("alt_data_%0d", i), 32'(rd_data), 32'(8'h80 + i));
            pop();
            check($sformatf("alt_cnt0_%0d", i), 32'(count), 32'd0);
        end

        // Reset mid-operation with count=5 and overflow set
        for (int i = 0; i < 17; i++) begin
            push(8'(8'hC0 + i));
        end
        for (int i = 0; i < 11; i++) begin
            pop();
        end
        check("prerst_count", 32'(count), 32'd5);
        check("prerst_ovf", 32'(overflow), 32'd1);
        check("prerst_data", 32'(rd_data), 32'hCB);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_empty", 32'(empty), 32'd1);
        check("async_rst_count", 32'(count), 32'd0);
        check("async_rst_ovf", 32'(overflow), 32'd0);
        tick();
        reset = 1'b0;
        tick();
        check("postrst_empty", 32'(empty), 32'd1);
        push(8'h3C);
        check("postrst_data", 32'(rd_data), 32'h3C);
        check("postrst_count", 32'(count), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive-side buffer between the UART receiver and the consuming logic (host interface / display / command decoder). Captures each byte the receiver flags as complete, stores up to 2^ADDR_BITS bytes in order, and presents the oldest byte first-word-fall-through to the reader. Reports occupancy and full/empty status, and keeps a sticky overflow flag for bytes dropped while full.

## Interface
- DBITS, 8, data word width; matches the receiver's data width.
- ADDR_BITS, 4, pointer width; depth = 2^ADDR_BITS (16).
- clk_100MHz  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high; clock clk_100MHz.
- wr_en  in  1  push request; driven by the receiver's one-cycle data_ready pulse.
- wr_data  in  DBITS  byte to push; sampled only when wr_en=1.
- rd_en  in  1  pop request from the consumer.
- clr_overflow  in  1  clears the sticky overflow flag.
- rd_data  out  DBITS  oldest stored byte; valid whenever empty=0.
- empty  out  1  no bytes stored.
- full  out  1  2^ADDR_BITS bytes stored.
- count  out  ADDR_BITS+1  occupancy, 0 to 2^ADDR_BITS.
- overflow  out  1  sticky: a push was dropped.

## Operation
- Storage: 2^ADDR_BITS x DBITS register array; wr_ptr and rd_ptr are ADDR_BITS+1 bits wide, and the MSB disambiguates full from empty.
- empty = (wr_ptr == rd_ptr); full = (MSBs differ and low bits equal); count = wr_ptr - rd_ptr, computed modulo 2^(ADDR_BITS+1).
- Push accepted when wr_en=1 and (full=0 or rd_en=1): mem[wr_ptr low bits] <= wr_data, wr_ptr increments.
- Pop accepted when rd_en=1 and empty=0: rd_ptr increments.
- Pointers wrap naturally at 2^(ADDR_BITS+1). No special case is needed at address wrap.
- Simultaneous push and pop:
  - Not empty, not full: both happen; count unchanged.
  - Full: both happen; the new byte takes the freed slot, full stays 1, overflow not set.
  - Empty: push happens, pop is ignored; count becomes 1.
- Push while full without rd_en: byte discarded, pointers unchanged, overflow <= 1.
- Pop while empty: ignored, no flag, pointers unchanged.
- overflow: set has priority over clr_overflow in the same cycle; otherwise clr_overflow=1 clears it next cycle.
- No FSM. Control state is pointers plus overflow; status outputs are decoded combinationally from pointer registers.

## Timing
- Reset (async assert, sync-to-clock release by the top level):
  - wr_ptr=0, rd_ptr=0, overflow=0.
  - Outputs: empty=1, full=0, count=0, rd_data = mem[0] (undefined content; do not rely on it).
  - Memory contents are not reset.
- Write-to-read latency: a byte pushed at edge N appears on rd_data, with empty=0, after edge N (visible in cycle N+1) when the FIFO was empty.
- Pop: rd_data updates to the next byte in the cycle after the edge where rd_en was accepted.
- count, full and empty all reflect pushes and pops committed at the preceding edge.
- Reset mid-operation discards all contents immediately and clears overflow.
- Throughput: one push and one pop per cycle. wr_en pulses from the receiver are at least 16 sample ticks apart, but the design must not depend on that.

## Structure
- Shared package uart_pkg: DBITS default and ADDR_BITS default, shared with the receiver, transmitter and tx FIFO.
- One natural sub-module: uart_fifo_mem, the register array with synchronous write and asynchronous read. It is reused by the tx FIFO.
- Pointer and flag logic stays in uart_rx_fifo, about 150 RTL lines total.

## Test plan
- Reset, then idle: empty=1, full=0, count=0, overflow=0; rd_en pulses leave count=0.
- Push 0x11, 0x22, 0x33, then pop three times: rd_data reads 0x11 → 0x22 → 0x33; count goes 3 → 0; empty=1 at the end.
- Push 16 bytes 0x00..0x0F: full=1, count=16. A 17th push of 0xAA without rd_en: overflow=1 and count=16. Drain the FIFO: 0x00..0x0F in order with no 0xAA. Pulse clr_overflow: overflow=0.
- While full, push 0x55 with rd_en=1: count stays 16, overflow stays 0. Drain: 0x01..0x0F then 0x55.
- While empty, push 0x77 with rd_en=1: count=1 and rd_data=0x77. Then run 40 alternating push/pop cycles across pointer wrap: data stays in order and count never exceeds 1.
- Assert reset with count=5 and overflow=1: empty=1, count=0, overflow=0 immediately. After release, a push of 0x3C is read back as 0x3C.
